// File: rtl/argon_mem_ctrl.sv
// argon_mem_ctrl: core load/store port onto a single-port word RAM.
// Aligns store lanes, extends load results and rejects illegal accesses.
module argon_mem_ctrl #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned RAM_AW      = 30
) (
    input  logic              sys_clk,
    input  logic              i_reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wr_data,
    input  logic [2:0]        i_rd_mask,
    input  logic [1:0]        i_wr_mask,
    output logic              o_ready,
    output logic [31:0]       o_rd_data,
    output logic              o_err,
    output logic              o_busy,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [3:0]        o_ram_be,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    localparam logic [2:0] RD_NONE = 3'd0;
    localparam logic [2:0] RD_LBU  = 3'd1;
    localparam logic [2:0] RD_LB   = 3'd2;
    localparam logic [2:0] RD_LHU  = 3'd3;
    localparam logic [2:0] RD_LH   = 3'd4;
    localparam logic [2:0] RD_LW   = 3'd5;

    localparam logic [1:0] WR_NONE = 2'd0;
    localparam logic [1:0] WR_SB   = 2'd1;
    localparam logic [1:0] WR_SH   = 2'd2;
    localparam logic [1:0] WR_SW   = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  lane_q;
    logic [2:0]  rd_mask_q;

    logic        req_none;
    logic        req_illegal;
    logic        req_store;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Request decode, evaluated against the live inputs in IDLE.
    always_comb begin
        req_none    = (i_rd_mask == RD_NONE) && (i_wr_mask == WR_NONE);
        req_store   = (i_wr_mask != WR_NONE);
        req_illegal = 1'b0;
        if ((i_rd_mask != RD_NONE) && (i_wr_mask != WR_NONE))
            req_illegal = 1'b1;
        if (i_rd_mask > RD_LW)
            req_illegal = 1'b1;
        if (((i_rd_mask == RD_LHU) || (i_rd_mask == RD_LH)) && i_addr[0])
            req_illegal = 1'b1;
        if ((i_rd_mask == RD_LW) && (i_addr[1:0] != 2'b00))
            req_illegal = 1'b1;
        if ((i_wr_mask == WR_SH) && i_addr[0])
            req_illegal = 1'b1;
        if ((i_wr_mask == WR_SW) && (i_addr[1:0] != 2'b00))
            req_illegal = 1'b1;
    end

    always_comb begin
        req_be    = 4'b1111;
        req_wdata = i_wr_data;
        unique case (i_wr_mask)
            WR_SB: begin
                req_be    = 4'b0001 << i_addr[1:0];
                req_wdata = {4{i_wr_data[7:0]}};
            end
            WR_SH: begin
                req_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{i_wr_data[15:0]}};
            end
            WR_SW: begin
                req_be    = 4'b1111;
                req_wdata = i_wr_data;
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = i_wr_data;
            end
        endcase
    end

    // Load lane select and extension from the RAM word.
    always_comb begin
        ld_byte = i_ram_rdata[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? i_ram_rdata[31:16] : i_ram_rdata[15:0];
        ld_data = i_ram_rdata;
        unique case (rd_mask_q)
            RD_LBU:  ld_data = {24'd0, ld_byte};
            RD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            RD_LHU:  ld_data = {16'd0, ld_half};
            RD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            default: ld_data = i_ram_rdata;
        endcase
    end

    always_ff @(posedge sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            lane_q      <= 2'b00;
            rd_mask_q   <= RD_NONE;
            o_ready     <= 1'b0;
            o_rd_data   <= 32'd0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_ram_en    <= 1'b0;
            o_ram_we    <= 1'b0;
            o_ram_be    <= 4'b0000;
            o_ram_addr  <= '0;
            o_ram_wdata <= 32'd0;
        end else begin
            o_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_req) begin
                        lane_q    <= i_addr[1:0];
                        rd_mask_q <= i_rd_mask;
                        o_busy    <= 1'b1;
                        if (req_illegal || req_none) begin
                            state     <= DONE;
                            o_ready   <= 1'b1;
                            o_err     <= req_illegal;
                            o_rd_data <= 32'd0;
                        end else begin
                            state       <= ACCESS;
                            cnt         <= 4'd0;
                            o_err       <= 1'b0;
                            o_ram_en    <= 1'b1;
                            o_ram_we    <= req_store;
                            o_ram_be    <= req_be;
                            o_ram_addr  <= i_addr[RAM_AW+1:2];
                            o_ram_wdata <= req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == WS) begin
                        cnt      <= 4'd0;
                        o_ram_en <= 1'b0;
                        o_ram_we <= 1'b0;
                        o_ram_be <= 4'b0000;
                        if (rd_mask_q != RD_NONE) begin
                            state <= CAPTURE;
                        end else begin
                            state     <= DONE;
                            o_ready   <= 1'b1;
                            o_rd_data <= 32'd0;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CAPTURE: begin
                    state     <= DONE;
                    o_ready   <= 1'b1;
                    o_rd_data <= ld_data;
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    o_err  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argon_mem_ctrl.sv
// tb_argon_mem_ctrl: directed table plus random loads/stores against a
// byte-array memory model, on a zero-wait and a three-wait instance.
module tb_argon_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_clr;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  rm;
    logic [1:0]  wm;

    logic        rdy0, err0, busy0, en0, we0;
    logic [3:0]  be0;
    logic [29:0] ad0;
    logic [31:0] rd0, wd0, rr0;
    logic        rdy3, err3, busy3, en3, we3;
    logic [3:0]  be3;
    logic [29:0] ad3;
    logic [31:0] rd3, wd3, rr3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    argon_mem_ctrl #(.WAIT_STATES(0), .RAM_AW(30)) u0 (
        .sys_clk(clk), .i_reset(rst), .i_req(req), .i_addr(addr),
        .i_wr_data(wdata), .i_rd_mask(rm), .i_wr_mask(wm),
        .o_ready(rdy0), .o_rd_data(rd0), .o_err(err0), .o_busy(busy0),
        .o_ram_en(en0), .o_ram_we(we0), .o_ram_be(be0),
        .o_ram_addr(ad0), .o_ram_wdata(wd0), .i_ram_rdata(rr0)
    );

    argon_mem_ctrl #(.WAIT_STATES(3), .RAM_AW(30)) u3 (
        .sys_clk(clk), .i_reset(rst), .i_req(req), .i_addr(addr),
        .i_wr_data(wdata), .i_rd_mask(rm), .i_wr_mask(wm),
        .o_ready(rdy3), .o_rd_data(rd3), .o_err(err3), .o_busy(busy3),
        .o_ram_en(en3), .o_ram_we(we3), .o_ram_be(be3),
        .o_ram_addr(ad3), .o_ram_wdata(wd3), .i_ram_rdata(rr3)
    );

    // One synchronous RAM per instance; both see identical command streams.
    logic [31:0] mem0 [256];
    logic [31:0] mem3 [256];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem0[i] <= 32'd0;
            rr0 <= 32'd0;
        end else if (en0) begin
            if (we0) begin
                for (int i = 0; i < 4; i++)
                    if (be0[i]) mem0[ad0[7:0]][8*i +: 8] <= wd0[8*i +: 8];
            end else begin
                rr0 <= mem0[ad0[7:0]];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem3[i] <= 32'd0;
            rr3 <= 32'd0;
        end else if (en3) begin
            if (we3) begin
                for (int i = 0; i < 4; i++)
                    if (be3[i]) mem3[ad3[7:0]][8*i +: 8] <= wd3[8*i +: 8];
            end else begin
                rr3 <= mem3[ad3[7:0]];
            end
        end
    end

    // Reference: flat byte memory and the access rules.
    logic [7:0]  ref_mem [1024];
    logic        x_store;
    logic [3:0]  x_be;
    logic [31:0] x_wd;
    logic [29:0] x_ad;

    task automatic model(input logic [2:0] r, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic err, output logic [31:0] rdv_o,
                         output int lat0);
        int sz;
        logic bad;
        logic [31:0] v;
        if (r == 1 || r == 2 || w == 1) sz = 1;
        else if (r == 3 || r == 4 || w == 2) sz = 2;
        else sz = 4;
        bad = (r != 0 && w != 0) || (r >= 6) ||
              ((r != 0 || w != 0) && (int'(a[1:0]) % sz != 0));
        err = bad;
        rdv_o = 32'd0;
        x_store = 1'b0;
        x_be = 4'd0;
        x_wd = 32'd0;
        x_ad = a[31:2];
        if (bad || (r == 0 && w == 0)) begin
            lat0 = 1;
        end else if (w != 0) begin
            lat0 = 2;
            x_store = 1'b1;
            x_be = 4'(((1 << sz) - 1) << a[1:0]);
            x_wd = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
            for (int i = 0; i < sz; i++)
                ref_mem[int'(a[9:0]) + i] = d[8*i +: 8];
        end else begin
            lat0 = 3;
            x_be = 4'hF;
            v = 32'd0;
            for (int i = 0; i < sz; i++)
                v = v | (32'(ref_mem[int'(a[9:0]) + i]) << (8 * i));
            if (r == 2 && v[7]) v = v | 32'hFFFF_FF00;
            if (r == 4 && v[15]) v = v | 32'hFFFF_0000;
            rdv_o = v;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    int          lat [2];
    int          nrdy [2];
    int          nen [2];
    int          nbusy [2];
    logic        bad [2];
    logic        erv [2];
    logic [31:0] rdv [2];
    logic [3:0]  fbe [2];
    logic [31:0] fwd [2];

    task automatic sample(input int d, input int k, input logic r_y,
                          input logic e_r, input logic b_y, input logic e_n,
                          input logic w_e, input logic [3:0] b_e,
                          input logic [29:0] a_d, input logic [31:0] w_d,
                          input logic [31:0] r_d);
        if (r_y) begin
            nrdy[d]++;
            if (lat[d] == 0) begin
                lat[d] = k;
                rdv[d] = r_d;
                erv[d] = e_r;
            end
        end
        if (b_y && lat[d] == 0) nbusy[d]++;
        if (e_n) begin
            if (nen[d] == 0) begin
                fbe[d] = b_e;
                fwd[d] = w_d;
            end
            nen[d]++;
            if (w_e !== x_store || b_e !== x_be || a_d !== x_ad ||
                (x_store && w_d !== x_wd)) bad[d] = 1'b1;
        end else if (w_e || b_e != 4'd0) begin
            bad[d] = 1'b1;
        end
    endtask

    // Starts at a negedge; issues one request and watches 10 cycles.
    task automatic xact(input string nm, input logic [2:0] r,
                        input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d, input bit dup);
        logic m_err;
        logic [31:0] m_rd;
        int m_lat, ws, el;
        string tag;
        model(r, w, a, d, m_err, m_rd, m_lat);
        for (int i = 0; i < 2; i++) begin
            lat[i] = 0; nrdy[i] = 0; nen[i] = 0; nbusy[i] = 0;
            bad[i] = 1'b0; erv[i] = 1'b0; rdv[i] = 32'd0;
            fbe[i] = 4'd0; fwd[i] = 32'd0;
        end
        req = 1'b1; rm = r; wm = w; addr = a; wdata = d;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req = dup;
                if (dup) begin
                    addr = a ^ 32'h4; rm = 3'd1; wm = 2'd0;
                end
            end
            if (k == 2) req = 1'b0;
            sample(0, k, rdy0, err0, busy0, en0, we0, be0, ad0, wd0, rd0);
            sample(1, k, rdy3, err3, busy3, en3, we3, be3, ad3, wd3, rd3);
        end
        for (int i = 0; i < 2; i++) begin
            ws = (i == 1) ? 3 : 0;
            tag = (i == 1) ? {nm, " u3"} : {nm, " u0"};
            el = (m_lat == 1) ? 1 : m_lat + ws;
            chk({tag, " latency"}, 32'(lat[i]), 32'(el));
            chk({tag, " ready_count"}, 32'(nrdy[i]), 32'd1);
            chk({tag, " err"}, 32'(erv[i]), 32'(m_err));
            chk({tag, " rd_data"}, rdv[i], m_rd);
            chk({tag, " en_cycles"}, 32'(nen[i]),
                (m_lat == 1) ? 32'd0 : 32'(ws + 1));
            chk({tag, " ram_bus"}, 32'(bad[i]), 32'd0);
            chk({tag, " busy_cycles"}, 32'(nbusy[i]), 32'(el - 1));
        end
    endtask

    typedef struct {
        logic [2:0]  r;
        logic [1:0]  w;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl [19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  r;
        logic [1:0]  w;
        logic [31:0] a;
        logic        quiet;
        int          op;

        tbl[0]  = '{3'd0, 2'd3, 32'h80, 32'h8844_22F1, 1'b0, 32'h0, 4'hF, 32'h8844_22F1};
        tbl[1]  = '{3'd2, 2'd0, 32'h80, 32'h0, 1'b0, 32'hFFFF_FFF1, 4'hF, 32'h0};
        tbl[2]  = '{3'd1, 2'd0, 32'h83, 32'h0, 1'b0, 32'h0000_0088, 4'hF, 32'h0};
        tbl[3]  = '{3'd4, 2'd0, 32'h82, 32'h0, 1'b0, 32'hFFFF_8844, 4'hF, 32'h0};
        tbl[4]  = '{3'd3, 2'd0, 32'h80, 32'h0, 1'b0, 32'h0000_22F1, 4'hF, 32'h0};
        tbl[5]  = '{3'd5, 2'd0, 32'h80, 32'h0, 1'b0, 32'h8844_22F1, 4'hF, 32'h0};
        tbl[6]  = '{3'd0, 2'd2, 32'h46, 32'h1234_ABCD, 1'b0, 32'h0, 4'hC, 32'hABCD_ABCD};
        tbl[7]  = '{3'd5, 2'd0, 32'h44, 32'h0, 1'b0, 32'hABCD_0000, 4'hF, 32'h0};
        tbl[8]  = '{3'd0, 2'd1, 32'h45, 32'hFFFF_FF5A, 1'b0, 32'h0, 4'h2, 32'h5A5A_5A5A};
        tbl[9]  = '{3'd5, 2'd0, 32'h44, 32'h0, 1'b0, 32'hABCD_5A00, 4'hF, 32'h0};
        tbl[10] = '{3'd2, 2'd0, 32'h45, 32'h0, 1'b0, 32'h0000_005A, 4'hF, 32'h0};
        tbl[11] = '{3'd5, 2'd0, 32'h02, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0};
        tbl[12] = '{3'd4, 2'd0, 32'h01, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0};
        tbl[13] = '{3'd5, 2'd3, 32'h80, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0};
        tbl[14] = '{3'd6, 2'd0, 32'h80, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0};
        tbl[15] = '{3'd0, 2'd0, 32'h80, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
        tbl[16] = '{3'd0, 2'd2, 32'h43, 32'h1111_2222, 1'b1, 32'h0, 4'h0, 32'h0};
        tbl[17] = '{3'd0, 2'd3, 32'h41, 32'h3333_4444, 1'b1, 32'h0, 4'h0, 32'h0};
        tbl[18] = '{3'd4, 2'd0, 32'h46, 32'h0, 1'b0, 32'hFFFF_ABCD, 4'hF, 32'h0};

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;
        rst = 1'b1; mem_clr = 1'b1; req = 1'b0;
        addr = 32'd0; wdata = 32'd0; rm = 3'd0; wm = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset u0 outputs", 32'(|{rdy0, err0, busy0, en0, we0, be0, ad0, wd0, rd0}), 32'd0);
        chk("reset u3 outputs", 32'(|{rdy3, err3, busy3, en3, we3, be3, ad3, wd3, rd3}), 32'd0);
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            xact($sformatf("tbl%0d", i), tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0);
            chk($sformatf("tbl%0d err", i), 32'(erv[0]), 32'(tbl[i].e));
            chk($sformatf("tbl%0d rd_data", i), rdv[0], tbl[i].rd);
            chk($sformatf("tbl%0d be", i), 32'(fbe[0]), 32'(tbl[i].be));
            if (tbl[i].w != 2'd0)
                chk($sformatf("tbl%0d wdata", i), fwd[0], tbl[i].wd);
        end

        xact("dup_req", 3'd5, 2'd0, 32'h80, 32'h0, 1'b1);

        // Reset during the second ACCESS cycle of the wait-state instance.
        req = 1'b1; rm = 3'd5; wm = 2'd0; addr = 32'h10;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("pre_reset u3 en", 32'(en3), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_reset u3 outputs", 32'(|{rdy3, err3, busy3, en3, we3, be3, ad3, wd3, rd3}), 32'd0);
        chk("async_reset u0 outputs", 32'(|{rdy0, err0, busy0, en0, we0, be0, ad0, wd0, rd0}), 32'd0);
        @(negedge clk);
        req = 1'b1; rm = 3'd5; addr = 32'h10;
        @(negedge clk);
        req = 1'b0;
        quiet = !(rdy0 || rdy3 || busy0 || busy3 || en0 || en3);
        @(negedge clk);
        quiet = quiet && !(rdy0 || rdy3 || busy0 || busy3 || en0 || en3);
        chk("req_during_reset ignored", 32'(quiet), 32'd1);
        rst = 1'b0;
        xact("sw_after_reset", 3'd0, 2'd3, 32'h10, 32'hCAFE_F00D, 1'b0);
        xact("lw_after_reset", 3'd5, 2'd0, 32'h10, 32'h0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            op = int'($urandom_range(0, 9));
            a = 32'($urandom_range(0, 1023));
            if (op <= 4) begin
                r = 3'(op + 1); w = 2'd0;
            end else if (op <= 7) begin
                r = 3'd0; w = 2'(op - 4);
            end else if (op == 8) begin
                r = 3'($urandom_range(1, 7)); w = 2'($urandom_range(1, 3));
            end else begin
                r = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(6, 7)) : 3'd0;
                w = 2'd0;
            end
            if ($urandom_range(0, 3) != 0) begin
                if (r == 3'd3 || r == 3'd4 || w == 2'd2) a[0] = 1'b0;
                if (r == 3'd5 || w == 2'd3) a[1:0] = 2'b00;
            end
            xact($sformatf("rnd%0d", n), r, w, a, $urandom, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/argon_mem_ctrl.md
ARGON_MEM_CTRL -- requirements
Module: argon_mem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, meaning extra RAM access cycles inserted per access (legal 0..15).
REQ-002 SHALL have parameter RAM_AW, default 30, meaning the RAM word-address width.
REQ-003 SHALL have port sys_clk, input, 1, the system clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset, input, 1, the reset: asynchronous, active-high.
REQ-005 SHALL have port i_req, input, 1, a one-cycle core access request strobe.
REQ-006 SHALL have port i_addr, input, 32, the byte address.
REQ-007 SHALL have port i_wr_data, input, 32, the store data, right-aligned.
REQ-008 SHALL have port i_rd_mask, input, 3, the load type: 0 none, 1 LBU, 2 LB, 3 LHU, 4 LH, 5 LW; 6-7 illegal.
REQ-009 SHALL have port i_wr_mask, input, 2, the store type: 0 none, 1 SB, 2 SH, 3 SW.
REQ-010 SHALL have port o_ready, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have port o_rd_data, output, 32, the extended load result, valid while o_ready=1.
REQ-012 SHALL have port o_err, output, 1, the error flag, valid while o_ready=1.
REQ-013 SHALL have port o_busy, output, 1, high whenever the FSM is not in IDLE.
REQ-014 SHALL have port o_ram_en, output, 1, the RAM enable.
REQ-015 SHALL have port o_ram_we, output, 1, the RAM write enable.
REQ-016 SHALL have port o_ram_be, output, 4, the byte enables, little-endian (bit0 = bits 7:0).
REQ-017 SHALL have port o_ram_addr, output, RAM_AW, the word address, i_addr[RAM_AW+1:2].
REQ-018 SHALL have port o_ram_wdata, output, 32, the lane-replicated write data.
REQ-019 SHALL have port i_ram_rdata, input, 32, the RAM read data, valid one cycle after o_ram_en with o_ram_we=0.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, CAPTURE, DONE.
REQ-021 SHALL accept i_req only in IDLE, latching addr/data/masks; i_req in other states is ignored, not queued.
REQ-022 SHALL classify a request as illegal when both masks are nonzero, i_rd_mask>=6, a halfword has addr[0]=1, or a word has addr[1:0]!=0.
REQ-023 SHALL, for an illegal request, go IDLE->DONE with no RAM activity and o_err=1, o_rd_data=0.
REQ-024 SHALL, for a request with both masks 0, go IDLE->DONE with o_err=0, o_rd_data=0, and no RAM activity.
REQ-025 SHALL, for a legal access, go IDLE->ACCESS and hold o_ram_en=1 with stable addr/be/we/wdata for WAIT_STATES+1 cycles, counted by a 4-bit counter.
REQ-026 SHALL, after ACCESS, go to CAPTURE for loads (i_ram_rdata registered) and to DONE for stores.
REQ-027 SHALL go CAPTURE->DONE->IDLE, with o_ready=1 for exactly the DONE cycle.
REQ-028 SHALL give latency from the i_req edge to the o_ready cycle of: illegal/none 1 cycle, store WAIT_STATES+2, load WAIT_STATES+3.
REQ-029 SHALL drive SB as be = 1<<addr[1:0] with wdata = byte replicated x4.
REQ-030 SHALL drive SH as be = 0011 (addr[1]=0) or 1100, with wdata = half replicated x2.
REQ-031 SHALL drive SW as be = 1111 with wdata = i_wr_data.
REQ-032 SHALL drive loads with o_ram_we=0 and be=1111.
REQ-033 SHALL select the load lane by addr[1:0] (byte) or addr[1] (half); LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-034 SHALL hold o_ram_en, o_ram_we and o_ram_be at 0 outside ACCESS.

Reset
REQ-035 SHALL, on i_reset asserted (including mid-access), immediately force the FSM to IDLE, the counter to 0, and o_ready, o_err, o_busy, o_ram_en, o_ram_we to 0, o_ram_be to 0, and o_rd_data, o_ram_addr, o_ram_wdata to 0.
REQ-036 SHALL ignore i_req during reset, and SHALL accept i_req in the first cycle after reset deasserts.

Verification
REQ-037 SHALL be verified with WAIT_STATES=0: RAM word 0x80 = 0x8844_22F1; LB @0x80 -> o_ready 3 cycles later with o_rd_data=0xFFFF_FFF1; LBU @0x83 -> 0x0000_0088; LH @0x82 -> 0xFFFF_8844.
REQ-038 SHALL be verified with SH data 0x1234_ABCD @0x46: o_ram_be=1100, o_ram_wdata=0xABCD_ABCD, o_ram_we=1 for 1 cycle, o_ready 2 cycles after i_req.
REQ-039 SHALL be verified with WAIT_STATES=3: LW @0x10 -> o_ram_en high for exactly 4 cycles, o_ready 6 cycles after i_req, o_busy high for 5 cycles before o_ready.
REQ-040 SHALL be verified with illegal requests (LW @0x02, LH @0x01, rd_mask=5 with wr_mask=3): each gives o_ready+o_err 1 cycle later, o_ram_en never asserted.
REQ-041 SHALL be verified with i_reset asserted during the 2nd ACCESS cycle of WAIT_STATES=3: o_ram_en drops the same cycle, no o_ready, and a new SW issued after reset completes normally.
REQ-042 SHALL be verified with a second i_req while o_busy=1: it is ignored, with exactly one o_ready produced.
